pb_debounce: RTL and testbench

Debounces and conditions the four active-low board pushbuttons before they reach the Nios II pushbutton PIO input port. The block synchronises each raw pin into the system clock domain and filters it with a per-channel counter state machine. It drives a clean, active-high pressed level to the PIO `in_port`. It also produces one-cycle press/release pulses and sticky event flags for interrupt or edge-capture logic downstream.

---
 rtl/pb_debounce.sv | 138 +++++++++++++
 tb/tb_pb_debounce.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce.sv
// Pushbutton conditioner: two-flop synchroniser plus a per-channel counter FSM
// producing a debounced pressed level, press/release pulses and sticky event flags.
module pb_debounce #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pb_raw,
  input  logic [WIDTH-1:0] event_clear,
  output logic [WIDTH-1:0] pb_level,
  output logic [WIDTH-1:0] pb_press,
  output logic [WIDTH-1:0] pb_release,
  output logic [WIDTH-1:0] pb_event
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] REL_LVL  = {WIDTH{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] p;

  state_t           st      [WIDTH];
  state_t           st_nxt  [WIDTH];
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] level_nxt;
  logic [WIDTH-1:0] press_nxt;
  logic [WIDTH-1:0] release_nxt;

  // Stage 1-2: bring the asynchronous pins into the clk domain, idle at released level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= REL_LVL;
      s2 <= REL_LVL;
    end else begin
      s1 <= pb_raw;
      s2 <= s1;
    end
  end

  assign p = (ACTIVE_LOW != 0) ? ~s2 : s2;

  // Stage 3: debounce FSM state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        st[i]  <= RELEASED;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        st[i]  <= st_nxt[i];
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    level_nxt   = '0;
    press_nxt   = '0;
    release_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      st_nxt[i]  = st[i];
      cnt_nxt[i] = cnt[i];
      unique case (st[i])
        RELEASED: begin
          if (p[i]) begin
            st_nxt[i]  = PRESS_WAIT;
            cnt_nxt[i] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!p[i]) begin
            st_nxt[i]  = RELEASED;
            cnt_nxt[i] = '0;
          end else if (cnt[i] == CNT_LAST) begin
            st_nxt[i]    = PRESSED;
            cnt_nxt[i]   = '0;
            press_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!p[i]) begin
            st_nxt[i]  = RELEASE_WAIT;
            cnt_nxt[i] = '0;
          end
        end
        RELEASE_WAIT: begin
          if (p[i]) begin
            st_nxt[i]  = PRESSED;
            cnt_nxt[i] = '0;
          end else if (cnt[i] == CNT_LAST) begin
            st_nxt[i]      = RELEASED;
            cnt_nxt[i]     = '0;
            release_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          st_nxt[i]  = RELEASED;
          cnt_nxt[i] = '0;
        end
      endcase
      level_nxt[i] = (st_nxt[i] == PRESSED) || (st_nxt[i] == RELEASE_WAIT);
    end
  end

  // Stage 3 outputs: registered alongside the state so level and pulses change together
  always_ff @(posedge clk) begin
    if (reset) begin
      pb_level   <= '0;
      pb_press   <= '0;
      pb_release <= '0;
      pb_event   <= '0;
    end else begin
      pb_level   <= level_nxt;
      pb_press   <= press_nxt;
      pb_release <= release_nxt;
      // a press pulse arriving together with a clear keeps the flag set
      pb_event   <= pb_press | (pb_event & ~event_clear);
    end
  end

endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench for pb_debounce with STABLE_CYCLES=8, ACTIVE_LOW=1 (11-edge latency).
module tb_pb_debounce;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pb_raw;
  logic [W-1:0] event_clear;
  logic [W-1:0] pb_level;
  logic [W-1:0] pb_press;
  logic [W-1:0] pb_release;
  logic [W-1:0] pb_event;

  int n_tests = 0;
  int n_fail  = 0;

  pb_debounce #(.WIDTH(W), .STABLE_CYCLES(8), .ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .pb_raw     (pb_raw),
    .event_clear(event_clear),
    .pb_level   (pb_level),
    .pb_press   (pb_press),
    .pb_release (pb_release),
    .pb_event   (pb_event)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; pb_raw = 4'b0000; event_clear = 4'b0000;
    tick(3);
    n_tests++;
    if ({pb_level, pb_press, pb_release, pb_event} !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_outputs got %h want 0000", {pb_level, pb_press, pb_release, pb_event});
    end
    // buttons held through reset: full latency from deassertion
    reset = 1'b0;
    tick(10);
    n_tests++;
    if (pb_level !== 4'b0000 || pb_press !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_held_early level=%b press=%b want 0000/0000", pb_level, pb_press);
    end
    tick(1);
    n_tests++;
    if (pb_level !== 4'b1111 || pb_press !== 4'b1111) begin
      n_fail++;
      $display("FAIL rst_held_accept level=%b press=%b want 1111/1111", pb_level, pb_press);
    end
    // release everything and confirm a quiet idle with pins high
    pb_raw = 4'b1111;
    tick(11);
    n_tests++;
    if (pb_level !== 4'b0000 || pb_release !== 4'b1111) begin
      n_fail++;
      $display("FAIL rst_rel level=%b release=%b want 0000/1111", pb_level, pb_release);
    end
    event_clear = 4'b1111;
    tick(1);
    event_clear = 4'b0000;
    n_tests++;
    if (pb_event !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_evclr got %b want 0000", pb_event);
    end
    for (int k = 0; k < 15; k++) begin
      tick(1);
      n_tests++;
      if ({pb_level, pb_press, pb_release, pb_event} !== 16'h0) begin
        n_fail++;
        $display("FAIL idle_quiet k=%0d got %h want 0000", k, {pb_level, pb_press, pb_release, pb_event});
      end
    end
  endtask

  task automatic test_clean_press;
    pb_raw[0] = 1'b0;
    tick(10);
    n_tests++;
    if (pb_level[0] !== 1'b0 || pb_press[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL press_early level=%b press=%b want 0/0", pb_level[0], pb_press[0]);
    end
    tick(1);
    n_tests++;
    if (pb_level !== 4'b0001 || pb_press !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_edge level=%b press=%b want 0001/0001", pb_level, pb_press);
    end
    tick(1);
    n_tests++;
    if (pb_press !== 4'b0000 || pb_level !== 4'b0001 || pb_event !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_after press=%b level=%b event=%b want 0000/0001/0001", pb_press, pb_level, pb_event);
    end
  endtask

  task automatic test_bounce;
    logic [15:0] pat;
    // bit k = pin level during tick k: low 5, high 2, low 6, then high
    pat = 16'b1110_0000_0110_0000;
    for (int k = 0; k < 16; k++) begin
      pb_raw[1] = pat[k];
      tick(1);
      n_tests++;
      if (pb_level[1] !== 1'b0 || pb_press !== 4'b0000) begin
        n_fail++;
        $display("FAIL bounce k=%0d level1=%b press=%b want 0/0000", k, pb_level[1], pb_press);
      end
    end
    pb_raw[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      n_tests++;
      if (pb_level[1] !== 1'b0 || pb_press !== 4'b0000) begin
        n_fail++;
        $display("FAIL bounce_tail k=%0d level1=%b press=%b want 0/0000", k, pb_level[1], pb_press);
      end
    end
  endtask

  task automatic test_release;
    pb_raw[0] = 1'b1;
    tick(10);
    n_tests++;
    if (pb_level[0] !== 1'b1 || pb_release[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_early level=%b release=%b want 1/0", pb_level[0], pb_release[0]);
    end
    tick(1);
    n_tests++;
    if (pb_level[0] !== 1'b0 || pb_release !== 4'b0001) begin
      n_fail++;
      $display("FAIL rel_edge level=%b release=%b want 0/0001", pb_level[0], pb_release);
    end
    tick(1);
    n_tests++;
    if (pb_release !== 4'b0000) begin
      n_fail++;
      $display("FAIL rel_pulse_width got %b want 0000", pb_release);
    end
    // press again, then release with a 3-cycle low glitch mid-count
    pb_raw[0] = 1'b0;
    tick(12);
    pb_raw[0] = 1'b1;
    tick(5);
    pb_raw[0] = 1'b0;
    tick(3);
    pb_raw[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      n_tests++;
      if (pb_level[0] !== 1'b1 || pb_release[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_hold k=%0d level=%b release=%b want 1/0", k, pb_level[0], pb_release[0]);
      end
    end
    tick(1);
    n_tests++;
    if (pb_level[0] !== 1'b0 || pb_release[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_rel level=%b release=%b want 0/1", pb_level[0], pb_release[0]);
    end
    tick(1);
  endtask

  task automatic test_event_clear;
    pb_raw[2] = 1'b0;
    tick(11);
    n_tests++;
    if (pb_press[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL evc_press got %b want 1", pb_press[2]);
    end
    event_clear[2] = 1'b1;
    tick(1);
    n_tests++;
    if (pb_event[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL evc_collision got %b want 1", pb_event[2]);
    end
    tick(1);
    event_clear[2] = 1'b0;
    n_tests++;
    if (pb_event[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL evc_clear got %b want 0", pb_event[2]);
    end
    tick(2);
    n_tests++;
    if (pb_event[2] !== 1'b0 || pb_level[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL evc_stay event=%b level=%b want 0/1", pb_event[2], pb_level[2]);
    end
  endtask

  task automatic test_back_to_back;
    pb_raw = 4'b1111;
    tick(12);
    pb_raw = 4'b0000;
    tick(10);
    n_tests++;
    if (pb_press !== 4'b0000 || pb_level !== 4'b0000) begin
      n_fail++;
      $display("FAIL all_early press=%b level=%b want 0000/0000", pb_press, pb_level);
    end
    tick(1);
    n_tests++;
    if (pb_press !== 4'b1111 || pb_level !== 4'b1111) begin
      n_fail++;
      $display("FAIL all_press press=%b level=%b want 1111/1111", pb_press, pb_level);
    end
    pb_raw = 4'b1111;
    tick(12);
    // press again and reset once the counters reach 4
    pb_raw = 4'b0000;
    tick(7);
    reset = 1'b1;
    tick(2);
    n_tests++;
    if ({pb_level, pb_press, pb_release, pb_event} !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_rst got %h want 0000", {pb_level, pb_press, pb_release, pb_event});
    end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      n_tests++;
      if (pb_level !== 4'b0000 || pb_press !== 4'b0000) begin
        n_fail++;
        $display("FAIL mid_rst_hold k=%0d level=%b press=%b want 0000/0000", k, pb_level, pb_press);
      end
    end
    tick(1);
    n_tests++;
    if (pb_press !== 4'b1111 || pb_level !== 4'b1111) begin
      n_fail++;
      $display("FAIL mid_rst_accept press=%b level=%b want 1111/1111", pb_press, pb_level);
    end
    tick(1);
    n_tests++;
    if (pb_event !== 4'b1111 || pb_press !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_rst_event event=%b press=%b want 1111/0000", pb_event, pb_press);
    end
  endtask

  initial begin
    reset = 1'b1;
    pb_raw = 4'b1111;
    event_clear = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_event_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
